// File: rtl/x86_bus_pkg.sv
// x86_bus_pkg: tag kinds, EU FSM states and reset vector shared by the BIU
package x86_bus_pkg;
  typedef enum logic {TAG_FETCH = 1'b0, TAG_EU_RD = 1'b1} tag_kind_e;
  typedef struct packed {
    logic      valid;
    tag_kind_e kind;
  } tag_t;
  typedef enum logic [1:0] {EU_IDLE = 2'd0, EU_WR = 2'd1, EU_RD_WAIT = 2'd2} eu_state_e;
  localparam logic [19:0] RESET_VECTOR = 20'hFFFF0;
endpackage

// File: rtl/x86_biu_if.sv
// x86_biu_if: BIU bus bundle
//   mem side : o_mem_addr/o_mem_data/o_mem_write out, i_mem_data in
//   EU side  : i_eu_req/i_eu_we/i_eu_addr/i_eu_wdata in, o_eu_ack/o_eu_rdata out
//   queue    : i_flush/i_flush_addr/i_q_pop in, o_q_valid/o_q_byte out
//   master = BIU, slave = surrounding system
interface x86_biu_if;
  logic [19:0] o_mem_addr;
  logic [7:0]  o_mem_data;
  logic        o_mem_write;
  logic [7:0]  i_mem_data;
  logic        i_eu_req;
  logic        i_eu_we;
  logic [19:0] i_eu_addr;
  logic [7:0]  i_eu_wdata;
  logic        o_eu_ack;
  logic [7:0]  o_eu_rdata;
  logic        i_flush;
  logic [19:0] i_flush_addr;
  logic        o_q_valid;
  logic [7:0]  o_q_byte;
  logic        i_q_pop;
  modport master (
    output o_mem_addr, o_mem_data, o_mem_write, o_eu_ack, o_eu_rdata, o_q_valid, o_q_byte,
    input  i_mem_data, i_eu_req, i_eu_we, i_eu_addr, i_eu_wdata, i_flush, i_flush_addr, i_q_pop
  );
  modport slave (
    input  o_mem_addr, o_mem_data, o_mem_write, o_eu_ack, o_eu_rdata, o_q_valid, o_q_byte,
    output i_mem_data, i_eu_req, i_eu_we, i_eu_addr, i_eu_wdata, i_flush, i_flush_addr, i_q_pop
  );
endinterface

// File: rtl/x86_pfq_fifo.sv
// x86_pfq_fifo: DEPTH x 8 circular prefetch queue with combinational head
//   clk, rst_n (sync, active low); clr empties the queue and beats push/pop
//   push/din write the tail; pop consumes the head (ignored when empty)
//   dout = head byte, valid = non-empty, count = bytes held
module x86_pfq_fifo #(
  parameter int DEPTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          pop_ok;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    pop_ok = pop && count_q != '0;
    mem_d = mem_q;
    if (push && !clr) mem_d[tail_q] = din;
    head_d = clr ? '0 : pop_ok ? nxt(head_q) : head_q;
    tail_d = clr ? '0 : push ? nxt(tail_q) : tail_q;
    count_d = clr ? '0 : count_q + CW'(push) - CW'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  assign dout = mem_q[head_q];
  assign valid = count_q != '0;
  assign count = count_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !clr && count_q == CW'(DEPTH)));
endmodule

// File: rtl/x86_biu_prefetch.sv
// x86_biu_prefetch: 8086 BIU with prefetch queue, EU byte access and flush
//   clk, rst_n (sync, active low); bus (x86_biu_if.master) carries mem, EU and queue signals
//   one access issued per edge, EU before prefetch; a LATENCY-deep tag pipeline routes returned bytes
module x86_biu_prefetch import x86_bus_pkg::*; #(
  parameter int          DEPTH      = 6,
  parameter int          LATENCY    = 2,
  parameter logic [19:0] RESET_ADDR = RESET_VECTOR
) (
  input logic        clk,
  input logic        rst_n,
  x86_biu_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  eu_state_e     state_q, state_d;
  logic [19:0]   fptr_q, fptr_d, addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic          write_q, write_d, ack_q, ack_d;
  tag_t          tags_q [LATENCY];
  tag_t          tags_d [LATENCY];
  logic [CW-1:0] count;
  logic          eu_issue, fetch_issue, push, rd_done;
  int            in_flight;
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < LATENCY; i++) in_flight += int'(tags_q[i].valid && tags_q[i].kind == TAG_FETCH);
    eu_issue = state_q == EU_IDLE && bus.i_eu_req;
    // outstanding fetches reserve queue slots so a returning byte always fits
    fetch_issue = !eu_issue && !bus.i_flush && int'(count) + in_flight < DEPTH;
    push = tags_q[LATENCY-1].valid && tags_q[LATENCY-1].kind == TAG_FETCH && !bus.i_flush;
    rd_done = tags_q[LATENCY-1].valid && tags_q[LATENCY-1].kind == TAG_EU_RD;
    addr_d = eu_issue ? bus.i_eu_addr : fetch_issue ? fptr_q : addr_q;
    wdata_d = eu_issue && bus.i_eu_we ? bus.i_eu_wdata : wdata_q;
    write_d = eu_issue && bus.i_eu_we;
    ack_d = write_d || rd_done;
    rdata_d = rd_done ? bus.i_mem_data : rdata_q;
    fptr_d = bus.i_flush ? bus.i_flush_addr : fetch_issue ? fptr_q + 20'd1 : fptr_q;
    state_d = state_q;
    if (eu_issue) state_d = bus.i_eu_we ? EU_WR : EU_RD_WAIT;
    else if (state_q == EU_WR || (state_q == EU_RD_WAIT && ack_q)) state_d = EU_IDLE;
    tags_d[0] = tag_t'{valid: fetch_issue || (eu_issue && !bus.i_eu_we), kind: eu_issue ? TAG_EU_RD : TAG_FETCH};
    for (int i = 1; i < LATENCY; i++) tags_d[i] = tags_q[i-1];
    // flush kills fetches in flight but EU reads still complete
    if (bus.i_flush)
      for (int i = 0; i < LATENCY; i++) if (tags_d[i].kind == TAG_FETCH) tags_d[i].valid = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EU_IDLE;
      fptr_q <= RESET_ADDR;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      ack_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) tags_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fptr_q <= fptr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      ack_q <= ack_d;
      tags_q <= tags_d;
    end
  end
  x86_pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.i_flush),
    .push  (push),
    .pop   (bus.i_q_pop),
    .din   (bus.i_mem_data),
    .dout  (bus.o_q_byte),
    .valid (bus.o_q_valid),
    .count (count)
  );
  assign bus.o_mem_addr = addr_q;
  assign bus.o_mem_data = wdata_q;
  assign bus.o_mem_write = write_q;
  assign bus.o_eu_ack = ack_q;
  assign bus.o_eu_rdata = rdata_q;
endmodule

// File: tb/tb_x86_biu_prefetch.sv
// tb_x86_biu_prefetch: directed checks of prefetch, flush, EU access and reset
module tb_x86_biu_prefetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [19:0] d1 = '0;
  logic [19:0] wr_a = '0;
  logic [7:0]  wr_d = '0;
  logic        wr_v = 1'b0;
  x86_biu_if bus();
  x86_biu_prefetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= bus.o_mem_addr;
    if (bus.o_mem_write) begin
      wr_v <= 1'b1;
      wr_a <= bus.o_mem_addr;
      wr_d <= bus.o_mem_data;
    end
  end
  always_comb bus.i_mem_data = (wr_v && d1 == wr_a) ? wr_d : (d1 == 20'h00100) ? 8'hA5 : d1[7:0];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic eu_rd(input logic [19:0] a, input logic [7:0] exp);
    int c;
    bus.i_eu_req = 1'b1;
    bus.i_eu_we = 1'b0;
    bus.i_eu_addr = a;
    tick;
    check("rd_issue_addr", bus.o_mem_addr, a);
    c = 1;
    while (!bus.o_eu_ack && c < 10) begin
      tick;
      c++;
    end
    bus.i_eu_req = 1'b0;
    check("rd_latency", c, 3);
    check("rd_data", bus.o_eu_rdata, exp);
    tick;
    check("rd_ack_pulse", bus.o_eu_ack, 0);
  endtask
  initial begin
    bus.i_eu_req = 1'b0;
    bus.i_eu_we = 1'b0;
    bus.i_eu_addr = '0;
    bus.i_eu_wdata = '0;
    bus.i_flush = 1'b0;
    bus.i_flush_addr = '0;
    bus.i_q_pop = 1'b0;
    tick;
    tick;
    check("rst_addr", bus.o_mem_addr, 0);
    check("rst_data", bus.o_mem_data, 0);
    check("rst_write", bus.o_mem_write, 0);
    check("rst_ack", bus.o_eu_ack, 0);
    check("rst_rdata", bus.o_eu_rdata, 0);
    check("rst_qvalid", bus.o_q_valid, 0);
    check("rst_qbyte", bus.o_q_byte, 0);
    rst_n = 1'b1;
    repeat (12) tick;
    check("fill_addr", bus.o_mem_addr, 20'hFFFF5);
    check("fill_head", {bus.o_q_valid, bus.o_q_byte}, {1'b1, 8'hF0});
    repeat (3) tick;
    check("fill_hold", bus.o_mem_addr, 20'hFFFF5);
    for (int k = 0; k < 16; k++) begin
      check("stream", {bus.o_q_valid, bus.o_q_byte}, {1'b1, 8'(8'hF0 + k)});
      bus.i_q_pop = 1'b1;
      tick;
    end
    bus.i_q_pop = 1'b0;
    bus.i_flush = 1'b1;
    bus.i_flush_addr = 20'h01234;
    tick;
    bus.i_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("flush_empty", bus.o_q_valid, 0);
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      check("flush_head", {bus.o_q_valid, bus.o_q_byte}, {1'b1, 8'(8'h34 + k)});
      bus.i_q_pop = 1'b1;
      tick;
    end
    bus.i_q_pop = 1'b0;
    bus.i_flush = 1'b1;
    bus.i_flush_addr = 20'hFFFFE;
    tick;
    bus.i_flush = 1'b0;
    repeat (10) tick;
    for (int k = 0; k < 4; k++) begin
      check("wrap", {bus.o_q_valid, bus.o_q_byte}, {1'b1, 8'(8'hFE + k)});
      bus.i_q_pop = 1'b1;
      tick;
    end
    bus.i_q_pop = 1'b0;
    eu_rd(20'h00100, 8'hA5);
    bus.i_eu_req = 1'b1;
    bus.i_eu_we = 1'b1;
    bus.i_eu_addr = 20'h00200;
    bus.i_eu_wdata = 8'h5A;
    tick;
    check("wr_strobe", bus.o_mem_write, 1);
    check("wr_addr", bus.o_mem_addr, 20'h00200);
    check("wr_data", bus.o_mem_data, 8'h5A);
    check("wr_ack", bus.o_eu_ack, 1);
    bus.i_eu_req = 1'b0;
    bus.i_eu_we = 1'b0;
    tick;
    check("wr_strobe_end", bus.o_mem_write, 0);
    check("wr_ack_end", bus.o_eu_ack, 0);
    eu_rd(20'h00200, 8'h5A);
    bus.i_flush = 1'b1;
    bus.i_flush_addr = 20'h00000;
    tick;
    bus.i_flush = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    check("mid_rst_addr", bus.o_mem_addr, 0);
    check("mid_rst_data", bus.o_mem_data, 0);
    check("mid_rst_write", bus.o_mem_write, 0);
    check("mid_rst_ack", bus.o_eu_ack, 0);
    check("mid_rst_rdata", bus.o_eu_rdata, 0);
    check("mid_rst_qvalid", bus.o_q_valid, 0);
    check("mid_rst_qbyte", bus.o_q_byte, 0);
    rst_n = 1'b1;
    tick;
    check("post_rst_fetch", bus.o_mem_addr, 20'hFFFF0);
    check("post_rst_empty1", bus.o_q_valid, 0);
    tick;
    check("post_rst_empty2", bus.o_q_valid, 0);
    tick;
    check("post_rst_head", {bus.o_q_valid, bus.o_q_byte}, {1'b1, 8'hF0});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
